async_fifo_prog: RTL and testbench
==================================

# async_fifo_prog

Parametrised dual-clock FIFO with Gray-coded pointer crossing, configurable synchroniser depth, occupancy counts on both sides, programmable almost-full/almost-empty flags and sticky overflow/underflow error reporting. It is the next-generation replacement for the team's basic asynchronous FIFO and sits between any two unrelated clock domains, e.g. a sensor/ADC capture domain and the processing domain. Storage uses the existing `dual_port_RAM` macro.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥4.
- `SYNC_STAGES`, 2: flops per pointer synchroniser, 2–4.
- `AF_LEVEL`, DEPTH-2: `walmost_full` asserts when write-side count ≥ AF_LEVEL; range 1..DEPTH.
- `AE_LEVEL`, 2: `ralmost_empty` asserts when read-side count ≤ AE_LEVEL; range 0..DEPTH-1.
- Derived, not overridable: `AW = $clog2(DEPTH)`.
- `wclk`, in, 1: write clock.
- `wrstn`, in, 1: write-domain reset. Reset `wrstn`, asynchronous, active-low; clock `wclk`.
- `rclk`, in, 1: read clock.
- `rrstn`, in, 1: read-domain reset; asynchronous, active-low.
- `winc`, in, 1: write request.
- `wdata`, in, WIDTH: write data, sampled on accepted writes.
- `wfull`, out, 1: FIFO full as seen from the write side.
- `walmost_full`, out, 1: write count ≥ AF_LEVEL.
- `wcount`, out, AW+1: write-side occupancy, 0..DEPTH.
- `woverflow`, out, 1: sticky; set by `winc` while `wfull`.
- `wclr_err`, in, 1: synchronous clear of `woverflow`.
- `rinc`, in, 1: read request.
- `rdata`, out, WIDTH: registered read data.
- `rvalid`, out, 1: one-cycle pulse; `rdata` is new this cycle.
- `rempty`, out, 1: FIFO empty as seen from the read side.
- `ralmost_empty`, out, 1: read count ≤ AE_LEVEL.
- `rcount`, out, AW+1: read-side occupancy.
- `runderflow`, out, 1: sticky; set by `rinc` while `rempty`.
- `rclr_err`, in, 1: synchronous clear of `runderflow`.

## Operation
- Pointers: `wbin`/`rbin` are AW+1-bit binary counters. `wgray`/`rgray` are registered from `bin_next ^ (bin_next>>1)` on the same edge as the binary update. No extra pipeline stage.
- Accepted write: `winc && !wfull`. `wbin` increments and the RAM is written at `wbin[AW-1:0]`. A write while full is dropped, the FIFO state is unchanged, and `woverflow` is set.
- Accepted read: `rinc && !rempty`. `rbin` increments; RAM is read at `rbin[AW-1:0]`. A read while empty is dropped and sets `runderflow`.
- Crossing: `wgray` passes through SYNC_STAGES flops in `rclk` (reset by `rrstn`), and `rgray` through SYNC_STAGES flops in `wclk` (reset by `wrstn`). Only Gray-coded registers cross domains.
- `rempty` = (`rgray` == synced `wgray`).
- `wfull` = (`wgray` == {~synced `rgray`[AW:AW-1], synced `rgray`[AW-2:0]}).
- `wcount` = `wbin` − gray2bin(synced `rgray`), modulo 2^(AW+1). `rcount` = gray2bin(synced `wgray`) − `rbin`.
- All flags and counts are combinational from registers, with no added latency. Both flags and counts are pessimistic: full/count may lag reads, and empty/count may lag writes.
- Error flags: the set has priority over a clear in the same cycle. Otherwise the flag holds until `wclr_err`/`rclr_err`.
- Wrap-around: pointers wrap at 2^(AW+1) naturally; the MSB disambiguates full from empty.

## Timing
- Reset values: `wfull`=0, `walmost_full`=(AF_LEVEL==0), `wcount`=0, `woverflow`=0, `rempty`=1, `ralmost_empty`=1, `rcount`=0, `rdata`=0, `rvalid`=0, `runderflow`=0.
- Read latency: `rdata` and `rvalid`=1 appear on the `rclk` edge after the accepted read. `rdata` holds its value between reads.
- Write-to-visible: `rempty` deasserts within SYNC_STAGES+1 `rclk` edges of the accepting `wclk` edge.
- Read-to-space: `wfull` deasserts within SYNC_STAGES+1 `wclk` edges.
- Simultaneous read and write when neither full nor empty: both are accepted in the same cycle.
- Reset mid-operation: both resets must be asserted together to flush the FIFO. Asserting one alone is unsupported; the contents are then undefined, but the flags of the reset side return to their reset values.

## Structure
- Package `fifo_pkg`: functions `bin2gray` and `gray2bin`, parametrised by width.
- Sub-module `gray_sync`: a SYNC_STAGES-deep, width-parametrised synchroniser with asynchronous active-low reset. It is instantiated twice.
- RAM: the existing `dual_port_RAM` with WIDTH and DEPTH passed through.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, SYNC_STAGES=2, AF_LEVEL=12, AE_LEVEL=2, wclk=10 ns, rclk=17 ns.
- Reset, then idle: `rempty`=1, `wfull`=0, both counts 0, `rdata`=0.
- Write 0x00–0x0F with no reads: `wfull`=1 after the 16th write and `wcount`=16. `walmost_full` first asserts after the 12th write. A 17th `winc` sets `woverflow`, and a later read returns 0x00, not the dropped word.
- Drain the full FIFO: `rdata` sequence is 0x00..0x0F, each with `rvalid`. `rempty`=1 after the last read. `ralmost_empty` is 1 whenever `rcount`≤2. Then `rinc` sets `runderflow`, and `rclr_err` clears it.
- Continuous concurrent streaming of 1000 random words with random `winc`/`rinc`: the read order matches the write order exactly, there are no errors, and pointers wrap more than 30 times.
- Single write into an empty FIFO: `rempty` falls within 3 `rclk` edges, and the `rdata` returned matches.
- Assert both resets while half-full (`wcount`=8): all outputs return to their reset values, and the next write/read pair passes 0xA5 correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared Gray-code helpers for the dual-clock FIFO pointers.
// Both functions are width-generic: narrower values are zero-extended in and cast back out.
package fifo_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; leading zeros from zero-extension leave the result intact.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i + 1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/dual_port_RAM.sv
// Simple dual-port storage: synchronous write on wclk, asynchronous read.
// The read register that owns reset and hold behaviour lives in the FIFO top.
module dual_port_RAM #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     wclk,
  input  logic                     wenc,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge wclk) begin
    if (wenc) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer entering another clock domain.
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift chain; only one bit of the Gray input can change per source edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_prog.sv
// Dual-clock FIFO with Gray pointer crossing, occupancy counts on both sides,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module async_fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic                     wclk,
  input  logic                     wrstn,
  input  logic                     rclk,
  input  logic                     rrstn,
  input  logic                     winc,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     wfull,
  output logic                     walmost_full,
  output logic [$clog2(DEPTH):0]   wcount,
  output logic                     woverflow,
  input  logic                     wclr_err,
  input  logic                     rinc,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     rempty,
  output logic                     ralmost_empty,
  output logic [$clog2(DEPTH):0]   rcount,
  output logic                     runderflow,
  input  logic                     rclr_err
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL = (AW + 1)'(AE_LEVEL);

  logic [AW:0]      wbin_q, wbin_d, wgray_q, wgray_d;
  logic             woverflow_q, woverflow_d;
  logic [AW:0]      rgray_sync_s, rq_bin_s, wcount_s;
  logic             wfull_s, wr_en_s;

  logic [AW:0]      rbin_q, rbin_d, rgray_q, rgray_d;
  logic             runderflow_q, runderflow_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [AW:0]      wgray_sync_s, wq_bin_s, rcount_s;
  logic             rempty_s, rd_en_s;
  logic [WIDTH-1:0] ram_rdata_s;

  // ---------------- write domain ----------------
  gray_sync #(.WIDTH(AW + 1), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk_i   (wclk),
    .rst_n_i (wrstn),
    .d_i     (rgray_q),
    .q_o     (rgray_sync_s)
  );

  // Full when the pointers differ only in the top two Gray bits (one lap apart)
  assign wfull_s  = (wgray_q == {~rgray_sync_s[AW:AW-1], rgray_sync_s[AW-2:0]});
  assign wr_en_s  = winc & ~wfull_s;
  assign rq_bin_s = (AW + 1)'(gray2bin(32'(rgray_sync_s)));
  assign wcount_s = wbin_q - rq_bin_s;

  // Write pointer and overflow next state; a set beats a simultaneous clear
  always_comb begin
    wbin_d      = wbin_q + {{AW{1'b0}}, wr_en_s};
    wgray_d     = (AW + 1)'(bin2gray(32'(wbin_d)));
    woverflow_d = woverflow_q;
    if (winc && wfull_s) begin
      woverflow_d = 1'b1;
    end else if (wclr_err) begin
      woverflow_d = 1'b0;
    end else begin
      woverflow_d = woverflow_q;
    end
  end

  // Write-domain state
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wgray_q     <= wgray_d;
      woverflow_q <= woverflow_d;
    end
  end

  assign wfull        = wfull_s;
  assign wcount       = wcount_s;
  assign walmost_full = (wcount_s >= AF_LVL);
  assign woverflow    = woverflow_q;

  dual_port_RAM #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .wclk  (wclk),
    .wenc  (wr_en_s),
    .waddr (wbin_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rbin_q[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  // ---------------- read domain ----------------
  gray_sync #(.WIDTH(AW + 1), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk_i   (rclk),
    .rst_n_i (rrstn),
    .d_i     (wgray_q),
    .q_o     (wgray_sync_s)
  );

  assign rempty_s = (rgray_q == wgray_sync_s);
  assign rd_en_s  = rinc & ~rempty_s;
  assign wq_bin_s = (AW + 1)'(gray2bin(32'(wgray_sync_s)));
  assign rcount_s = wq_bin_s - rbin_q;

  // Read pointer, output register and underflow next state
  always_comb begin
    rbin_d       = rbin_q + {{AW{1'b0}}, rd_en_s};
    rgray_d      = (AW + 1)'(bin2gray(32'(rbin_d)));
    rvalid_d     = rd_en_s;
    rdata_d      = rdata_q;
    runderflow_d = runderflow_q;
    if (rd_en_s) begin
      rdata_d = ram_rdata_s;
    end else begin
      rdata_d = rdata_q;
    end
    if (rinc && rempty_s) begin
      runderflow_d = 1'b1;
    end else if (rclr_err) begin
      runderflow_d = 1'b0;
    end else begin
      runderflow_d = runderflow_q;
    end
  end

  // Read-domain state
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign rempty        = rempty_s;
  assign rcount        = rcount_s;
  assign ralmost_empty = (rcount_s <= AE_LVL);
  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_async_fifo_prog.sv
// Directed self-checking bench for async_fifo_prog (DEPTH=16, wclk 10 ns, rclk 17 ns).
module tb_async_fifo_prog;

  logic       wclk = 1'b0;
  logic       rclk = 1'b0;
  logic       wrstn, rrstn;
  logic       winc, wclr_err, rinc, rclr_err;
  logic [7:0] wdata;
  logic       wfull, walmost_full, woverflow;
  logic [4:0] wcount, rcount;
  logic [7:0] rdata;
  logic       rvalid, rempty, ralmost_empty, runderflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  int wsent, rgot, rissued, edges;

  always #5   wclk = ~wclk;
  always #8.5 rclk = ~rclk;

  async_fifo_prog #(
    .WIDTH(8), .DEPTH(16), .SYNC_STAGES(2), .AF_LEVEL(12), .AE_LEVEL(2)
  ) dut (
    .wclk(wclk), .wrstn(wrstn), .rclk(rclk), .rrstn(rrstn),
    .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
    .wcount(wcount), .woverflow(woverflow), .wclr_err(wclr_err),
    .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rcount(rcount), .runderflow(runderflow),
    .rclr_err(rclr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rempty"}, rempty, 1);
    check({tag, "_wfull"}, wfull, 0);
    check({tag, "_wcount"}, wcount, 0);
    check({tag, "_rcount"}, rcount, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_walmost_full"}, walmost_full, 0);
    check({tag, "_ralmost_empty"}, ralmost_empty, 1);
    check({tag, "_woverflow"}, woverflow, 0);
    check({tag, "_runderflow"}, runderflow, 0);
  endtask

  initial begin
    wrstn = 1'b0; rrstn = 1'b0;
    winc = 1'b0; wclr_err = 1'b0; rinc = 1'b0; rclr_err = 1'b0; wdata = 8'h00;
    #30;
    check_reset_state("in_reset");
    wrstn = 1'b1; rrstn = 1'b1;
    repeat (3) @(posedge wclk);
    #1;
    check_reset_state("idle");

    // Fill with 0x00..0x0F, no reads
    for (int k = 1; k <= 16; k++) begin
      winc = 1'b1; wdata = 8'(k - 1);
      @(posedge wclk); #1;
      winc = 1'b0;
      check("fill_wcount", wcount, k);
      check("fill_walmost_full", walmost_full, (k >= 12) ? 1 : 0);
      check("fill_wfull", wfull, (k == 16) ? 1 : 0);
    end

    // 17th write with a clear in the same cycle: set must win
    winc = 1'b1; wdata = 8'hEE; wclr_err = 1'b1;
    @(posedge wclk); #1;
    winc = 1'b0; wclr_err = 1'b0;
    check("ovf_set", woverflow, 1);
    check("ovf_wcount", wcount, 16);
    wclr_err = 1'b1;
    @(posedge wclk); #1;
    wclr_err = 1'b0;
    check("ovf_clear", woverflow, 0);

    // Drain all 16
    repeat (4) @(posedge rclk);
    #1;
    check("pre_drain_rcount", rcount, 16);
    check("pre_drain_rempty", rempty, 0);
    for (int k = 0; k < 16; k++) begin
      rinc = 1'b1;
      @(posedge rclk); #1;
      rinc = 1'b0;
      check("drain_rvalid", rvalid, 1);
      check("drain_rdata", rdata, k);
      check("drain_rcount", rcount, 15 - k);
      check("drain_ralmost_empty", ralmost_empty, ((15 - k) <= 2) ? 1 : 0);
      check("drain_rempty", rempty, (k == 15) ? 1 : 0);
    end
    @(posedge rclk); #1;
    check("hold_rvalid", rvalid, 0);
    check("hold_rdata", rdata, 8'h0F);

    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    check("udf_set", runderflow, 1);
    check("udf_rvalid", rvalid, 0);
    rclr_err = 1'b1;
    @(posedge rclk); #1;
    rclr_err = 1'b0;
    check("udf_clear", runderflow, 0);
    repeat (4) @(posedge wclk);
    #1;
    check("drained_wfull", wfull, 0);
    check("drained_wcount", wcount, 0);

    // Single write into an empty FIFO
    winc = 1'b1; wdata = 8'h3C;
    @(posedge wclk); #1;
    winc = 1'b0;
    edges = 0;
    while (rempty && edges < 3) begin
      @(posedge rclk); #1;
      edges++;
    end
    check("single_rempty_fall", rempty, 0);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    check("single_rvalid", rvalid, 1);
    check("single_rdata", rdata, 8'h3C);

    // Concurrent random streaming of 1000 words
    wsent = 0; rgot = 0; rissued = 0;
    fork
      begin
        int g = 0;
        while (wsent < 1000 && g < 20000) begin
          @(posedge wclk); #1;
          g++;
          winc = 1'b0;
          if ($urandom_range(0, 1) == 1 && !wfull) begin
            winc = 1'b1;
            wdata = 8'($urandom);
            sb.push_back(wdata);
            wsent++;
          end
        end
        @(posedge wclk); #1;
        winc = 1'b0;
      end
      begin
        int g = 0;
        while (rgot < 1000 && g < 40000) begin
          @(posedge rclk); #1;
          g++;
          if (rvalid) begin
            check("stream_sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) check("stream_rdata", rdata, sb.pop_front());
            rgot++;
          end
          rinc = (rissued < 1000) && !rempty && ($urandom_range(0, 1) == 1);
          if (rinc) rissued++;
        end
        rinc = 1'b0;
      end
    join
    check("stream_written", wsent, 1000);
    check("stream_read", rgot, 1000);
    check("stream_woverflow", woverflow, 0);
    check("stream_runderflow", runderflow, 0);
    repeat (4) @(posedge wclk);
    #1;
    check("stream_end_wcount", wcount, 0);
    check("stream_end_rempty", rempty, 1);

    // Half-fill, then reset both domains together
    for (int k = 0; k < 8; k++) begin
      winc = 1'b1; wdata = 8'(8'h10 + k);
      @(posedge wclk); #1;
      winc = 1'b0;
    end
    check("half_wcount", wcount, 8);
    repeat (4) @(posedge rclk);
    #1;
    check("half_rcount", rcount, 8);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    check("half_rdata", rdata, 8'h10);
    wrstn = 1'b0; rrstn = 1'b0;
    #1;
    check_reset_state("midreset");
    #20;
    @(negedge wclk);
    wrstn = 1'b1; rrstn = 1'b1;
    repeat (2) @(posedge wclk);
    #1;
    check_reset_state("post_reset");
    winc = 1'b1; wdata = 8'hA5;
    @(posedge wclk); #1;
    winc = 1'b0;
    edges = 0;
    while (rempty && edges < 3) begin
      @(posedge rclk); #1;
      edges++;
    end
    check("a5_rempty_fall", rempty, 0);
    check("a5_rcount", rcount, 1);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    check("a5_rvalid", rvalid, 1);
    check("a5_rdata", rdata, 8'hA5);
    check("a5_rempty", rempty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
